// File: rtl/pid_line_pkg.sv
// Shared types and helpers for the line-follower PID controller.
package pid_line_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL_P = 3'd1,
    ST_MUL_I = 3'd2,
    ST_MUL_D = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  // Guard bits above gain*error so three summed products cannot overflow.
  localparam int ACC_GUARD_W = 2;

  function automatic int acc_width(input int gain_w, input int err_w);
    return gain_w + err_w + ACC_GUARD_W;
  endfunction

  function automatic int sens_weight(input int i, input int n);
    return 2 * i - (n - 1);
  endfunction

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/line_err_enc.sv
// Thresholds N sensor readings and encodes the line position as a signed weighted sum.
module line_err_enc
  import pid_line_pkg::*;
#(
  parameter int N_SENS = 4,
  parameter int ADC_W  = 12,
  parameter int ERR_W  = 8
) (
  input  logic [N_SENS*ADC_W-1:0] i_sample_data,
  input  logic [ADC_W-1:0]        i_thr,
  output logic signed [ERR_W-1:0] o_e,
  output logic                    o_any_line
);

  logic signed [ERR_W-1:0] w_sum;
  logic                    w_any;

  always_comb begin
    w_sum = '0;
    w_any = 1'b0;
    for (int i = 0; i < N_SENS; i++) begin
      if (i_sample_data[i*ADC_W +: ADC_W] > i_thr) begin
        w_sum = w_sum + ERR_W'(sens_weight(i, N_SENS));
        w_any = 1'b1;
      end
    end
  end

  assign o_e        = w_sum;
  assign o_any_line = w_any;

endmodule

// File: rtl/pid_line_ctrl.sv
// PID steering controller: one shared multiplier sequenced over five cycles per sample,
// with integrator clamping, lost-line timeout and saturated wheel duty outputs.
module pid_line_ctrl
  import pid_line_pkg::*;
#(
  parameter int N_SENS       = 4,
  parameter int ADC_W        = 12,
  parameter int ERR_W        = 8,
  parameter int GAIN_W       = 8,
  parameter int DUTY_W       = 8,
  parameter int INT_LIM      = 30,
  parameter int SHIFT        = 0,
  parameter int LOST_TIMEOUT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    sample_valid,
  input  logic [N_SENS*ADC_W-1:0] sample_data,
  input  logic [ADC_W-1:0]        thr,
  input  logic [GAIN_W-1:0]       kp,
  input  logic [GAIN_W-1:0]       ki,
  input  logic [GAIN_W-1:0]       kd,
  input  logic [DUTY_W-1:0]       base_duty,
  output logic [DUTY_W-1:0]       duty_l,
  output logic [DUTY_W-1:0]       duty_r,
  output logic                    duty_valid,
  output logic                    lost,
  output logic                    busy
);

  localparam int ACC_W  = acc_width(GAIN_W, ERR_W);
  localparam int SUM_W  = ((ACC_W > DUTY_W) ? ACC_W : DUTY_W) + 2;
  localparam int LCNT_W = $clog2(LOST_TIMEOUT + 1);
  localparam logic [LCNT_W-1:0]       LCNT_MAX  = LCNT_W'(LOST_TIMEOUT);
  localparam logic signed [SUM_W-1:0] DUTY_MAX  = SUM_W'((2 ** DUTY_W) - 1);

  function automatic logic [DUTY_W-1:0] sat_duty(input logic signed [SUM_W-1:0] v);
    if (v < 0)        return '0;
    if (v > DUTY_MAX) return '1;
    return v[DUTY_W-1:0];
  endfunction

  state_t                   r_state;
  logic signed [ERR_W-1:0]  r_e, r_integ, r_diff, r_prev_e;
  logic signed [1:0]        r_last_sign;
  logic [LCNT_W-1:0]        r_lost_cnt;
  logic                     r_lost;
  logic signed [ACC_W-1:0]  r_acc;
  logic [DUTY_W-1:0]        r_duty_l, r_duty_r;
  logic                     r_duty_valid;

  logic signed [ERR_W-1:0]  w_enc_e, w_e_nx, w_integ_nx, w_diff_nx, w_op;
  logic                     w_any_line, w_accept, w_going_lost;
  logic [LCNT_W-1:0]        w_lost_cnt_nx;
  logic [GAIN_W-1:0]        w_gain;
  logic signed [ACC_W-1:0]  w_prod, w_delta;
  logic signed [SUM_W-1:0]  w_base_s, w_delta_s;
  logic [DUTY_W-1:0]        w_duty_l, w_duty_r;

  line_err_enc #(
    .N_SENS (N_SENS),
    .ADC_W  (ADC_W),
    .ERR_W  (ERR_W)
  ) u_enc (
    .i_sample_data (sample_data),
    .i_thr         (thr),
    .o_e           (w_enc_e),
    .o_any_line    (w_any_line)
  );

  assign w_accept = (r_state == ST_IDLE) && sample_valid && enable;

  // A no-line sample steers hard toward the side the line was last seen on.
  always_comb begin
    w_e_nx        = w_enc_e;
    w_lost_cnt_nx = '0;
    if (!w_any_line) begin
      w_e_nx        = ERR_W'((N_SENS - 1) * int'(r_last_sign));
      w_lost_cnt_nx = (r_lost_cnt == LCNT_MAX) ? r_lost_cnt : r_lost_cnt + LCNT_W'(1);
    end
    w_going_lost = !w_any_line && (w_lost_cnt_nx == LCNT_MAX);
    w_integ_nx   = ERR_W'(clamp(int'(r_integ) + int'(w_e_nx), -INT_LIM, INT_LIM));
    w_diff_nx    = w_e_nx - r_prev_e;
  end

  always_comb begin
    w_gain = kp;
    w_op   = r_e;
    case (r_state)
      ST_MUL_I: begin w_gain = ki; w_op = r_integ; end
      ST_MUL_D: begin w_gain = kd; w_op = r_diff;  end
      default:  ;
    endcase
  end

  assign w_prod    = $signed({{(ACC_W-GAIN_W){1'b0}}, w_gain})
                   * $signed({{(ACC_W-ERR_W){w_op[ERR_W-1]}}, w_op});
  assign w_delta   = r_acc >>> SHIFT;
  assign w_base_s  = $signed({{(SUM_W-DUTY_W){1'b0}}, base_duty});
  assign w_delta_s = {{(SUM_W-ACC_W){w_delta[ACC_W-1]}}, w_delta};
  assign w_duty_l  = sat_duty(w_base_s + w_delta_s);
  assign w_duty_r  = sat_duty(w_base_s - w_delta_s);

  // Control and controller state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_integ      <= '0;
      r_prev_e     <= '0;
      r_last_sign  <= '0;
      r_lost_cnt   <= '0;
      r_lost       <= 1'b0;
      r_duty_l     <= '0;
      r_duty_r     <= '0;
      r_duty_valid <= 1'b0;
    end else begin
      r_duty_valid <= 1'b0;
      case (r_state)
        ST_IDLE:  if (w_accept) r_state <= ST_MUL_P;
        ST_MUL_P: r_state <= ST_MUL_I;
        ST_MUL_I: r_state <= ST_MUL_D;
        ST_MUL_D: r_state <= ST_OUT;
        ST_OUT: begin
          r_state      <= ST_IDLE;
          r_duty_valid <= 1'b1;
          r_duty_l     <= (enable && !r_lost) ? w_duty_l : '0;
          r_duty_r     <= (enable && !r_lost) ? w_duty_r : '0;
        end
        default:  r_state <= ST_IDLE;
      endcase

      if (!enable) begin
        r_integ     <= '0;
        r_prev_e    <= '0;
        r_last_sign <= '0;
        r_lost_cnt  <= '0;
        r_lost      <= 1'b0;
        r_duty_l    <= '0;
        r_duty_r    <= '0;
      end else if (w_accept) begin
        r_lost_cnt <= w_lost_cnt_nx;
        r_lost     <= w_going_lost;
        if (w_going_lost) begin
          r_integ     <= '0;
          r_prev_e    <= '0;
          r_last_sign <= '0;
        end else begin
          r_integ  <= w_integ_nx;
          r_prev_e <= w_e_nx;
          if (w_e_nx != '0) r_last_sign <= (w_e_nx < 0) ? 2'sb11 : 2'sb01;
        end
      end
    end
  end

  // Datapath: operand capture at acceptance, then one product per MUL state
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_e    <= w_going_lost ? '0 : w_e_nx;
      r_diff <= w_going_lost ? '0 : w_diff_nx;
    end
    case (r_state)
      ST_MUL_P:           r_acc <= w_prod;
      ST_MUL_I, ST_MUL_D: r_acc <= r_acc + w_prod;
      default:            ;
    endcase
  end

  assign duty_l     = r_duty_l;
  assign duty_r     = r_duty_r;
  assign duty_valid = r_duty_valid;
  assign lost       = r_lost;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pid_line_ctrl.sv
// Directed bench for pid_line_ctrl: table of sample vectors plus hand-written corner sequences.
module tb_pid_line_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        sample_valid = 1'b0;
  logic [47:0] sample_data = '0;
  logic [11:0] thr = 12'd500;
  logic [7:0]  kp = 8'd1, ki = 8'd1, kd = 8'd1;
  logic [7:0]  base_duty = 8'd60;
  logic [7:0]  duty_l, duty_r;
  logic        duty_valid, lost, busy;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  pid_line_ctrl #(
    .N_SENS(4), .ADC_W(12), .ERR_W(8), .GAIN_W(8), .DUTY_W(8),
    .INT_LIM(30), .SHIFT(0), .LOST_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
    .sample_data(sample_data), .thr(thr), .kp(kp), .ki(ki), .kd(kd),
    .base_duty(base_duty), .duty_l(duty_l), .duty_r(duty_r),
    .duty_valid(duty_valid), .lost(lost), .busy(busy)
  );

  typedef struct {
    bit          rst_before;
    logic [47:0] data;
    logic [7:0]  kp;
    int          exp_l;
    int          exp_r;
    bit          exp_lost;
  } vec_t;

  vec_t vecs[$];

  // Pattern string order: leftmost character is sensor 0.
  function automatic logic [47:0] mk(input logic [3:0] p);
    logic [47:0] d;
    for (int i = 0; i < 4; i++) d[i*12 +: 12] = p[3-i] ? 12'd800 : 12'd100;
    return d;
  endfunction

  task automatic add(input bit r, input logic [47:0] d, input logic [7:0] k,
                     input int el, input int er, input bit lo);
    vec_t v;
    v.rst_before = r; v.data = d; v.kp = k; v.exp_l = el; v.exp_r = er; v.exp_lost = lo;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sample_valid = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // Drives one sample in the current cycle T; returns in cycle T+5.
  task automatic apply(input logic [47:0] d, input logic [7:0] k, output bit tim_ok);
    sample_data = d; kp = k; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    tim_ok = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      if (busy !== 1'b1 || duty_valid !== 1'b0) tim_ok = 1'b0;
      step();
    end
    if (duty_valid !== 1'b1 || busy !== 1'b0) tim_ok = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [47:0] d;
    bit          ok;
    int          pulses;
    int          seen_l, seen_r;

    add(1, mk(4'b0110), 8'd1, 60, 60, 0);
    add(1, mk(4'b0011), 8'd1, 72, 48, 0);
    add(0, mk(4'b0011), 8'd1, 72, 48, 0);
    add(1, mk(4'b0001), 8'd1, 69, 51, 0);
    add(0, mk(4'b0001), 8'd1, 69, 51, 0);
    add(0, mk(4'b0001), 8'd1, 72, 48, 0);
    add(0, mk(4'b0001), 8'd1, 75, 45, 0);
    add(0, mk(4'b0001), 8'd1, 78, 42, 0);
    add(0, mk(4'b0001), 8'd1, 81, 39, 0);
    add(0, mk(4'b0001), 8'd1, 84, 36, 0);
    add(0, mk(4'b0001), 8'd1, 87, 33, 0);
    add(0, mk(4'b0001), 8'd1, 90, 30, 0);
    add(0, mk(4'b0001), 8'd1, 93, 27, 0);
    add(0, mk(4'b0001), 8'd1, 93, 27, 0);
    add(1, mk(4'b0011), 8'd100, 255, 0, 0);
    add(1, mk(4'b0011), 8'd1, 72, 48, 0);
    add(0, mk(4'b0000), 8'd1, 69, 51, 0);
    add(0, mk(4'b0000), 8'd1, 73, 47, 0);
    add(0, mk(4'b0000), 8'd1, 76, 44, 0);
    add(0, mk(4'b0000), 8'd1, 79, 41, 0);
    add(0, mk(4'b0000), 8'd1, 82, 38, 0);
    add(0, mk(4'b0000), 8'd1, 85, 35, 0);
    add(0, mk(4'b0000), 8'd1, 88, 32, 0);
    add(0, mk(4'b0000), 8'd1, 0, 0, 1);
    add(0, mk(4'b0110), 8'd1, 60, 60, 0);
    d = mk(4'b0010); d[36 +: 12] = 12'd500;
    add(1, d, 8'd1, 63, 57, 0);
    d = mk(4'b0000); d[36 +: 12] = 12'd501;
    add(1, d, 8'd1, 69, 51, 0);
    add(1, mk(4'b1000), 8'd1, 51, 69, 0);

    do_reset();
    chk("reset duty_l", 32'(duty_l), 0);
    chk("reset duty_r", 32'(duty_r), 0);
    chk("reset duty_valid", 32'(duty_valid), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset lost", 32'(lost), 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset();
      apply(vecs[i].data, vecs[i].kp, ok);
      chk($sformatf("vec%0d timing", i), 32'(ok), 1);
      chk($sformatf("vec%0d duty_l", i), 32'(duty_l), 32'(vecs[i].exp_l));
      chk($sformatf("vec%0d duty_r", i), 32'(duty_r), 32'(vecs[i].exp_r));
      chk($sformatf("vec%0d lost", i), 32'(lost), 32'(vecs[i].exp_lost));
    end
    kp = 8'd1;

    // Second sample arriving while busy is dropped.
    do_reset();
    sample_data = mk(4'b0110); sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    sample_data = mk(4'b0011); sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    pulses = 0; seen_l = -1; seen_r = -1;
    for (int c = 0; c < 14; c++) begin
      step();
      if (duty_valid === 1'b1) begin pulses++; seen_l = int'(duty_l); seen_r = int'(duty_r); end
    end
    chk("drop pulses", 32'(pulses), 1);
    chk("drop duty_l", 32'(seen_l), 60);
    chk("drop duty_r", 32'(seen_r), 60);

    // Reset during computation discards the sample.
    do_reset();
    apply(mk(4'b0011), 8'd1, ok);
    chk("prerst duty_l", 32'(duty_l), 72);
    sample_data = mk(4'b0001); sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst busy", 32'(busy), 0);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (duty_valid === 1'b1) pulses++;
    end
    chk("midrst pulses", 32'(pulses), 0);
    chk("midrst duty_l", 32'(duty_l), 0);
    chk("midrst duty_r", 32'(duty_r), 0);
    chk("midrst lost", 32'(lost), 0);

    // enable low forces zero duties, ignores samples and clears controller state.
    do_reset();
    apply(mk(4'b0011), 8'd1, ok);
    apply(mk(4'b0011), 8'd1, ok);
    enable = 1'b0;
    step(); step();
    chk("dis duty_l", 32'(duty_l), 0);
    chk("dis duty_r", 32'(duty_r), 0);
    sample_data = mk(4'b0001); sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (busy === 1'b1) pulses++;
      if (duty_valid === 1'b1) pulses++;
      step();
    end
    chk("dis ignored", 32'(pulses), 0);
    enable = 1'b1;
    step();
    apply(mk(4'b0011), 8'd1, ok);
    chk("reen timing", 32'(ok), 1);
    chk("reen duty_l", 32'(duty_l), 72);
    chk("reen duty_r", 32'(duty_r), 48);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pid_line_ctrl.md
# pid_line_ctrl

Parametrised PID steering controller for the line-follower drive path. It takes one vector of N ADC sensor readings per sample, thresholds each reading, and encodes the line position as a signed error. It runs a time-multiplexed PID computation with integrator clamping, then emits saturated left/right wheel duty commands to the PWM generators. The block adds four things to the first-generation controller: N-sensor generality, runtime gains and threshold, lost-line handling, and a valid handshake.

## Interface
Parameters:
- N_SENS, 4: sensor count; must be even and ≥2.
- ADC_W, 12: ADC sample width.
- ERR_W, 8: signed width of error, integrator and difference; must hold ±2·N_SENS² and ±INT_LIM.
- GAIN_W, 8: unsigned gain width.
- DUTY_W, 8: duty command width.
- INT_LIM, 30: integrator clamp magnitude.
- SHIFT, 0: arithmetic right shift applied to the PID sum (fixed-point gains).
- LOST_TIMEOUT, 8: number of consecutive no-line samples before stopping.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  controller run enable.
- sample_valid  in  1  sample_data valid for one cycle.
- sample_data  in  N_SENS·ADC_W  sensor i occupies [i·ADC_W +: ADC_W]; sensor 0 is leftmost.
- thr  in  ADC_W  line-detect threshold.
- kp, ki, kd  in  GAIN_W each  unsigned gains.
- base_duty  in  DUTY_W  straight-line duty.
- duty_l, duty_r  out  DUTY_W  wheel duty commands.
- duty_valid  out  1  one-cycle pulse when the duties update.
- lost  out  1  line lost past timeout.
- busy  out  1  computation in progress.

## Operation
- Detection: b_i = (sample_i > thr), strict comparison.
- Weights: w_i = 2i − (N_SENS−1), so N_SENS=4 gives −3, −1, +1, +3.
- Error: e = Σ w_i·b_i when any b_i is set.
- No-line sample (all b_i = 0):
  - e = (N_SENS−1)·last_sign, where last_sign is the sign of the most recent nonzero e (0 if there has been none).
  - lost_cnt increments, saturating at LOST_TIMEOUT.
- Any line sample clears lost_cnt and lost.
- Integrator: integ ← clamp(integ + e, −INT_LIM, +INT_LIM).
- Difference: diff = e − prev_e; then prev_e ← e.
- PID sum: delta = (kp·e + ki·integ + kd·diff) >>> SHIFT. The accumulator is signed with width GAIN_W+ERR_W+2 and must not overflow.
- Outputs:
  - duty_l = sat(base_duty + delta)
  - duty_r = sat(base_duty − delta)
  - sat clamps to [0, 2^DUTY_W − 1].
  - Positive e means the line is to the right, so the left wheel speeds up.
- When lost_cnt reaches LOST_TIMEOUT:
  - lost = 1, duty_l = duty_r = 0.
  - integ, prev_e and last_sign are cleared.
  - duty_valid still pulses.
- FSM states IDLE → MUL_P → MUL_I → MUL_D → OUT → IDLE. One shared multiplier; MUL_x accumulates one product per cycle.
- IDLE accepts a sample when sample_valid && enable.
- sample_valid in any state other than IDLE is dropped. There is no queueing.
- enable = 0:
  - Samples are ignored.
  - Duties are forced to 0.
  - integ, prev_e, last_sign and lost_cnt are cleared; lost = 0.
  - A computation already in flight completes, but its outputs are 0.
- Gains, thr and base_duty are sampled when used; changing them mid-computation is legal but the result is undefined.

## Timing
- Reset values:
  - duty_l = duty_r = 0; duty_valid = busy = lost = 0.
  - integ = prev_e = last_sign = lost_cnt = 0; state IDLE.
- Sample accepted at the edge ending cycle T: e, integ, diff and lost_cnt are registered at that edge.
- busy = 1 during cycles T+1..T+4.
- duty_l/duty_r are updated at the edge ending T+4; duty_valid = 1 during T+5 only.
- The next sample is accepted in T+5 or later, giving a maximum throughput of one sample per 5 cycles.
- rst asserted in any state returns the block to reset values on the next edge, and the in-flight sample is discarded.

## Structure
- Package pid_line_pkg holds:
  - the state enum;
  - the weight function w(i, N);
  - the saturating clamp function;
  - the accumulator-width localparam.
- Sub-module line_err_enc contains the combinational threshold and weighted sum, producing e and any_line. Everything else lives in pid_line_ctrl.

## Test plan
All scenarios use N_SENS=4, thr=500, kp=ki=kd=1, SHIFT=0, base_duty=60, INT_LIM=30, DUTY_W=8, enable=1, with a line reading of 800 and a background reading of 100.
- Pattern 0110 from reset → e=0; duty_valid at T+5; duties 60/60.
- Pattern 0011 from reset → e=4, integ=4, diff=4, delta=12 → 72/48. Repeat the sample → integ=8, diff=0 → 72/48.
- Ten consecutive 0001 samples → integ reaches 30 and clamps; the tenth sample gives delta=33 → 93/27. An eleventh sample gives the same output.
- kp=100 with 0011 → delta=408 → duty_l=255, duty_r=0.
- After a 0011 sample, send 0000 eight times:
  - the first seven give e=+3;
  - the eighth sets lost=1 with duties 0/0;
  - a following 0110 clears lost and gives 60/60.
- sample_valid pulsed at T+2 is dropped, and only one duty_valid pulse occurs.
- rst asserted at T+3 → no duty_valid pulse; all outputs 0.
